// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin request arbiter.
package arb_pkg;

  // Default number of requesters and default grant hold limit in cycles.
  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

  // Arbiter FSM states: waiting, serving one requester, datapath turnaround.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage : arb_pkg

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_req_arbiter_if
  import arb_pkg::*;
#(
  parameter int N = DEF_N
);

  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;      // level request per requester
  logic           done;     // current grantee finished
  logic [N-1:0]   gnt;      // one-hot grant
  logic [IDW-1:0] gnt_id;   // index of current grantee
  logic           busy;     // a grant is active
  logic           timeout;  // grant was force-released by the hold limit

  // Requester side drives requests and completion, observes grants.
  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout
  );

  // Arbiter side consumes requests and completion, produces grants.
  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout
  );

endinterface : rr_req_arbiter_if

// File: rtl/rr_req_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request at or above
// i_ptr, wrapping modulo N, plus the OR-reduction of the request vector.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_any,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IDW = $clog2(N);

  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_cand;
  logic           w_found;

  // Scan N candidates starting at the pointer; the first hit wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_cand = IDW'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign o_any = |i_req;
  assign o_idx = w_idx;

endmodule : rr_pick

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter sharing one datapath among N requesters. A grant is
// held until done, request withdrawal, or the hold limit, followed by one
// turnaround cycle before the next arbitration.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  rr_req_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(MAX_HOLD + 1);

  state_t          r_state,    w_state_nxt;
  logic [N-1:0]    r_gnt,      w_gnt_nxt;
  logic [IDW-1:0]  r_gnt_id,   w_gnt_id_nxt;
  logic            r_busy,     w_busy_nxt;
  logic            r_timeout,  w_timeout_nxt;
  logic [IDW-1:0]  r_ptr,      w_ptr_nxt;
  logic [CW-1:0]   r_hold_cnt, w_hold_cnt_nxt;

  logic            w_any;
  logic [IDW-1:0]  w_pick;
  logic [N-1:0]    w_pick_onehot;
  logic            w_rel_done;
  logic            w_rel_drop;
  logic            w_rel_max;
  logic            w_release;
  logic [IDW-1:0]  w_ptr_after;

  rr_pick #(.N(N)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_pick)
  );

  assign w_pick_onehot = {{(N-1){1'b0}}, 1'b1} << w_pick;

  // Release causes for the current grantee; done outranks the hold limit.
  assign w_rel_done  = bus.done;
  assign w_rel_drop  = ~bus.req[r_gnt_id];
  assign w_rel_max   = (r_hold_cnt == CW'(MAX_HOLD));
  assign w_release   = w_rel_done | w_rel_drop | w_rel_max;
  assign w_ptr_after = (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + IDW'(1);

  // State, outputs, pointer and hold counter register; reset wins over all.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Next-state and next-output logic; by default everything holds.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_busy_nxt     = r_busy;
    w_timeout_nxt  = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt    = ST_GRANT;
          w_gnt_nxt      = w_pick_onehot;
          w_gnt_id_nxt   = w_pick;
          w_busy_nxt     = 1'b1;
          w_hold_cnt_nxt = CW'(1);
        end
      end

      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt    = ST_GAP;
          w_gnt_nxt      = '0;
          w_gnt_id_nxt   = '0;
          w_busy_nxt     = 1'b0;
          w_ptr_nxt      = w_ptr_after;
          w_hold_cnt_nxt = '0;
          w_timeout_nxt  = w_rel_max & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + CW'(1);
        end
      end

      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_gnt_nxt      = '0;
        w_gnt_id_nxt   = '0;
        w_busy_nxt     = 1'b0;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule : rr_req_arbiter

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_rr_req_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_req_arbiter_if #(.N(N)) intf ();

  rr_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: who holds the grant (-1 = nobody), whether the
  // turnaround cycle is pending, how long the grant has lasted, the next
  // starting point of the search, and the forced-release pulse.
  int m_cur     = -1;
  int m_gap     = 0;
  int m_held    = 0;
  int m_ptr     = 0;
  int m_timeout = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_update(input logic r, input logic [N-1:0] q, input logic d);
    if (r) begin
      m_cur = -1; m_gap = 0; m_held = 0; m_ptr = 0; m_timeout = 0;
    end else if (m_cur >= 0) begin
      bit withdrew, at_limit;
      withdrew = !q[m_cur];
      at_limit = (m_held == MAX_HOLD);
      if (d || withdrew || at_limit) begin
        m_timeout = (at_limit && !d && !withdrew) ? 1 : 0;
        m_ptr     = (m_cur + 1) % N;
        m_cur     = -1;
        m_gap     = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0; m_timeout = 0;
    end else begin
      m_timeout = 0;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (m_cur < 0 && q[j]) m_cur = j;
      end
      if (m_cur >= 0) m_held = 1;
    end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_cur >= 0) ? N'(1) << m_cur : '0;
    check("gnt",     32'(intf.gnt),     32'(exp_gnt));
    check("gnt_id",  32'(intf.gnt_id),  (m_cur >= 0) ? 32'(m_cur) : 32'd0);
    check("busy",    32'(intf.busy),    (m_cur >= 0) ? 32'd1 : 32'd0);
    check("timeout", 32'(intf.timeout), 32'(m_timeout));
    check("onehot",  32'($countones(intf.gnt) <= 1), 32'd1);
    check("gnt_at_id", 32'(intf.gnt[intf.gnt_id]), 32'(intf.busy));
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then compare.
  task automatic step(input logic r, input logic [N-1:0] q, input logic d);
    @(negedge clk);
    rst       = r;
    intf.req  = q;
    intf.done = d;
    @(posedge clk);
    model_update(r, q, d);
    #1;
    compare_outputs();
  endtask

  initial begin
    int busy_cnt, to_cnt, idle_run, n_grants;
    logic prev_busy;
    int order[$];
    logic [N-1:0] rq;

    intf.req  = '0;
    intf.done = 1'b0;

    // 1: reset, then no requests.
    step(1'b1, 4'b0000, 1'b0);
    repeat (5) step(1'b0, 4'b0000, 1'b0);

    // 2: two requesters from ptr=0, done pulse, then ptr lands on 3.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0101, 1'b0);
    check("t2_first", 32'(intf.gnt), 32'h1);
    step(1'b0, 4'b0101, 1'b1);
    step(1'b0, 4'b0101, 1'b0);
    step(1'b0, 4'b0101, 1'b0);
    check("t2_second_id", 32'(intf.gnt_id), 32'd2);
    step(1'b0, 4'b0101, 1'b1);
    step(1'b0, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    check("t2_ptr3", 32'(intf.gnt_id), 32'd3);

    // 3: everyone requesting, done after two grant cycles each.
    step(1'b1, 4'b0000, 1'b0);
    prev_busy = 1'b0; idle_run = 0; n_grants = 0;
    for (int c = 0; c < 24; c++) begin
      step(1'b0, 4'b1111, (m_cur >= 0 && m_held == 2));
      if (intf.busy && !prev_busy) begin
        order.push_back(int'(intf.gnt_id));
        if (n_grants > 0) check("t3_spacing", 32'(idle_run), 32'd2);
        n_grants++;
        idle_run = 0;
      end else if (!intf.busy) begin
        idle_run++;
      end
      prev_busy = intf.busy;
    end
    check("t3_grants", 32'(order.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < order.size(); k++)
      check("t3_order", 32'(order[k]), 32'(k % N));

    // 4: single requester never finishes; forced release after MAX_HOLD.
    step(1'b1, 4'b0000, 1'b0);
    busy_cnt = 0; to_cnt = 0;
    for (int c = 0; c < MAX_HOLD + 2; c++) begin
      step(1'b0, 4'b0010, 1'b0);
      if (intf.busy) busy_cnt++;
      if (intf.timeout) begin
        to_cnt++;
        check("t4_to_pos", 32'(c), 32'(MAX_HOLD));
      end
    end
    check("t4_len", 32'(busy_cnt), 32'(MAX_HOLD));
    check("t4_to_cnt", 32'(to_cnt), 32'd1);

    // 5a: grantee withdraws mid-grant.
    step(1'b1, 4'b0000, 1'b0);
    repeat (3) step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check("t5_drop_gnt", 32'(intf.gnt), 32'h0);
    check("t5_drop_to", 32'(intf.timeout), 32'd0);

    // 5b: done coincides with the hold limit; no timeout.
    step(1'b1, 4'b0000, 1'b0);
    to_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < MAX_HOLD + 2; c++) begin
      step(1'b0, 4'b0100, (m_cur >= 0 && m_held == MAX_HOLD));
      if (intf.busy) busy_cnt++;
      if (intf.timeout) to_cnt++;
    end
    check("t5_len", 32'(busy_cnt), 32'(MAX_HOLD));
    check("t5_no_to", 32'(to_cnt), 32'd0);

    // 6: move ptr away from 0, reset mid-grant, ptr must be back at 0.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    repeat (5) step(1'b0, 4'b0010, 1'b0);
    check("t6_pre_id", 32'(intf.gnt_id), 32'd1);
    step(1'b1, 4'b0010, 1'b0);
    check("t6_rst_gnt", 32'(intf.gnt), 32'h0);
    check("t6_rst_busy", 32'(intf.busy), 32'd0);
    step(1'b0, 4'b1001, 1'b0);
    check("t6_after", 32'(intf.gnt), 32'h1);

    // Randomized traffic with sticky requests, random done and rare resets.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 30) rq = N'($urandom);
      step(($urandom_range(0, 199) == 0), rq, ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rr_req_arbiter
